// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and step/counter sizing helpers for serial_subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_width(input int width, input int digit);
        return $clog2(steps(width, digit)) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(8, 1);

endpackage

// File: rtl/serial_subtractor_slice.sv
// subtract_slice: combinational DIGIT-bit borrow-ripple subtractor, d = x - y - bin.
module subtract_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] t;

    // One spare MSB turns negative into a borrow-out.
    assign t    = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    assign d    = t[DIGIT-1:0];
    assign bout = t[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned a-b, DIGIT bits per clock, valid/ready on both sides.
// Define SERIAL_SUB_FLAGS_EN to add registered zero and signed-overflow outputs.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CW    = cnt_width(WIDTH, DIGIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic [DIGIT-1:0] slice_d;
    logic             slice_bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, zero_q, zero_d, ovf_q, ovf_d;
`endif

    subtract_slice #(.DIGIT(DIGIT)) u_slice (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
`ifdef SERIAL_SUB_FLAGS_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        if (state_q == IDLE && in_valid) begin
            state_d  = RUN;
            a_d      = a;
            b_d      = b;
            borrow_d = 1'b0;
            cnt_d    = '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            // New digits enter at the top so the last step leaves the result aligned.
            res_d    = WIDTH'({slice_d, res_q} >> DIGIT);
            borrow_d = slice_bout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
                state_d = DONE;
                diff_d  = {slice_bout, res_d};
`ifdef SERIAL_SUB_FLAGS_EN
                zero_d  = ~|res_d;
                ovf_d   = (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
`endif
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign diff      = diff_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench, random and directed operands against an arithmetic model.
// Also exercises a WIDTH=16/DIGIT=4 instance; flag checks follow SERIAL_SUB_FLAGS_EN.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready, in_ready, out_valid;
    logic [7:0] a, b;
    logic [8:0] diff;
    logic        v16, r16, ov16, ordy16;
    logic [15:0] a16, b16;
    logic [16:0] d16;
`ifdef SERIAL_SUB_FLAGS_EN
    logic zero, ovf, z16, o16;
    logic [1:0] flag_q[$];
`endif
    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .diff(diff)
`ifdef SERIAL_SUB_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy16), .diff(d16)
`ifdef SERIAL_SUB_FLAGS_EN
        , .zero(z16), .ovf(o16)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [8:0] model(input int unsigned x, input int unsigned y);
        logic [8:0] r;
        r[8]   = x < y;
        r[7:0] = 8'((x + 256 - y) % 256);
        return r;
    endfunction

    function automatic logic [1:0] model_flags(input int x, input int y);
        int sx = x >= 128 ? x - 256 : x;
        int sy = y >= 128 ? y - 256 : y;
        int s  = sx - sy;
        return {x == y, s < -128 || s > 127};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(diff), 32'h1ff);
            end else begin
                chk("diff", 32'(diff), 32'(exp_q.pop_front()));
`ifdef SERIAL_SUB_FLAGS_EN
                chk("flags", 32'({zero, ovf}), 32'(flag_q.pop_front()));
`endif
            end
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        int lat = 1;
        logic ir_ok = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        exp_q.push_back(model(x, y));
`ifdef SERIAL_SUB_FLAGS_EN
        flag_q.push_back(model_flags(x, y));
`endif
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            if (in_ready) ir_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'd9);
        chk("in_ready_low_in_run", 32'(ir_ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; ordy16 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'h05, 8'h03);
        send(8'h03, 8'h05);
        send(8'h00, 8'hff);
        send(8'ha5, 8'ha5);
        send(8'h80, 8'h01);
        send(8'h42, 8'h42);

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'h3c, 8'h5a);
        for (int i = 0; i < 5; i++) begin
            chk("bp_diff", 32'(diff), 32'(model(8'h3c, 8'h5a)));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("done_no_accept", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        chk("bp_out_valid_drop", 32'(out_valid), 32'd0);

        in_valid = 1'b1; a = 8'h77; b = 8'h11;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_run_in_ready", 32'(in_ready), 32'd1);
        chk("rst_run_out_valid", 32'(out_valid), 32'd0);
        chk("rst_run_diff", 32'(diff), 32'd0);
        send(8'h10, 8'h01);

        for (int i = 0; i < 20; i++) send(8'($urandom), 8'($urandom));

        @(negedge clk);
        chk("w16_in_ready", 32'(r16), 32'd1);
        v16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321;
        @(posedge clk);
        #1 v16 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov16 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w16_latency", 32'(lat), 32'd5);
        chk("w16_diff", 32'(d16), 32'h1cf13);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
